// File: rtl/saph_pixel_writer_pkg.sv
// saph_pixel_writer_pkg: framebuffer formats, pixel/command types and the clip/address/colour helpers
// Provides fb_fmt_t, pixel_t, mem_wr_cmd, fb_cfg_t, mem_state_t, is_clipped(), make_cmd().
package saph_pixel_writer_pkg;
  typedef enum logic [1:0] {FMT_ARGB8888, FMT_RGB565, FMT_RGB332, FMT_RSVD} fb_fmt_t;
  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic [31:0]        col;
  } pixel_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mem_wr_cmd;
  typedef struct packed {
    logic [31:0] base;
    logic [15:0] stride;
    logic [15:0] width;
    logic [15:0] height;
    fb_fmt_t     fmt;
  } fb_cfg_t;
  typedef enum logic {MEM_IDLE, MEM_REQ} mem_state_t;
  function automatic logic is_clipped(pixel_t p, fb_cfg_t c);
    return p.x[15] || p.y[15] || $unsigned(p.x) >= c.width || $unsigned(p.y) >= c.height ||
           c.fmt == FMT_RSVD;
  endfunction
  function automatic mem_wr_cmd make_cmd(pixel_t p, fb_cfg_t c);
    logic [31:0] ba, xo;
    logic [15:0] p565;
    logic [7:0]  p332;
    mem_wr_cmd   m;
    xo   = c.fmt == FMT_ARGB8888 ? {14'b0, p.x, 2'b0} :
           c.fmt == FMT_RGB565   ? {15'b0, p.x, 1'b0} : {16'b0, p.x};
    ba   = c.base + {16'b0, p.y} * {16'b0, c.stride} + xo;
    p565 = {p.col[23:19], p.col[15:10], p.col[7:3]};
    p332 = {p.col[23:21], p.col[15:13], p.col[7:6]};
    m.addr  = {ba[31:2], 2'b00};
    m.wdata = c.fmt == FMT_ARGB8888 ? p.col : c.fmt == FMT_RGB565 ? {2{p565}} : {4{p332}};
    m.wmask = c.fmt == FMT_ARGB8888 ? 4'b1111 :
              c.fmt == FMT_RGB565   ? (ba[1] ? 4'b1100 : 4'b0011) : 4'b0001 << ba[1:0];
    return m;
  endfunction
endpackage

// File: rtl/saph_pixel_writer_if.sv
// saph_pixel_writer_if: pixel-stream input and masked memory-write port of the pixel writer
// master: writer side (drives in_ready, mem_*); slave: producer/memory side (drives in_trig, in_pixel, mem_ack).
interface saph_pixel_writer_if;
  import saph_pixel_writer_pkg::*;
  logic        in_trig;
  pixel_t      in_pixel;
  logic        in_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ack;
  modport master (input in_trig, in_pixel, mem_ack,
                  output in_ready, mem_req, mem_addr, mem_wdata, mem_wmask);
  modport slave (output in_trig, in_pixel, mem_ack,
                 input in_ready, mem_req, mem_addr, mem_wdata, mem_wmask);
endinterface

// File: rtl/saph_sync_fifo.sv
// saph_sync_fifo: synchronous FIFO with the head entry presented straight from its storage registers
// Ports: clk, rst (async, active-low), push/wdata, pop/rdata, full, empty.
module saph_sync_fifo #(
  parameter type T     = logic [31:0],
  parameter int  DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     wdata,
  input  logic pop,
  output T     rdata,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  T mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;
  assign empty   = count == '0;
  assign full    = count == (AW+1)'(DEPTH);
  assign do_pop  = pop && !empty;
  // a full FIFO still takes a push when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/saph_pixel_writer.sv
// saph_pixel_writer: clips pixels, converts them to framebuffer writes and issues them on a req/ack port
// Ports: clk, rst (async, active-low), cfg_* framebuffer setup, bus (pixel stream in, memory writes out),
// busy (work in flight), clip_count (saturating count of dropped pixels).
module saph_pixel_writer
  import saph_pixel_writer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              cfg_base,
  input  logic [15:0]              cfg_stride,
  input  logic [15:0]              cfg_width,
  input  logic [15:0]              cfg_height,
  input  logic [1:0]               cfg_fmt,
  saph_pixel_writer_if.master      bus,
  output logic                     busy,
  output logic [CNT_W-1:0]         clip_count
);
  logic       started, s1_valid, s1_clip, s1_go, fifo_ok, accept, push, pop, full, empty;
  pixel_t     s1_pix;
  fb_cfg_t    s1_cfg;
  mem_wr_cmd  s1_cmd, head, mem_cmd;
  mem_state_t state, state_nxt;
  assign s1_clip      = is_clipped(s1_pix, s1_cfg);
  assign s1_cmd       = make_cmd(s1_pix, s1_cfg);
  assign pop          = !empty && (state == MEM_IDLE || bus.mem_ack);
  assign fifo_ok      = !full || pop;
  // clipped pixels leave S1 unconditionally; others need room in the FIFO
  assign s1_go        = s1_valid && (s1_clip || fifo_ok);
  assign push         = s1_valid && !s1_clip && fifo_ok;
  assign bus.in_ready = started && (!s1_valid || s1_go);
  assign accept       = bus.in_trig && bus.in_ready;
  assign bus.mem_req  = state == MEM_REQ;
  assign bus.mem_addr = mem_cmd.addr;
  assign bus.mem_wdata = mem_cmd.wdata;
  assign bus.mem_wmask = mem_cmd.wmask;
  assign busy         = s1_valid || !empty || bus.mem_req;
  saph_sync_fifo #(.T(mem_wr_cmd), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk, .rst, .push, .wdata(s1_cmd), .pop, .rdata(head), .full, .empty
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      started    <= 1'b0;
      s1_valid   <= 1'b0;
      s1_pix     <= '0;
      s1_cfg     <= '0;
      clip_count <= '0;
    end else begin
      started <= 1'b1;
      if (accept) begin
        s1_valid <= 1'b1;
        s1_pix   <= bus.in_pixel;
        s1_cfg   <= '{base: cfg_base, stride: cfg_stride, width: cfg_width, height: cfg_height,
                      fmt: fb_fmt_t'(cfg_fmt)};
      end else if (s1_go) s1_valid <= 1'b0;
      if (s1_valid && s1_clip) clip_count <= clip_count + CNT_W'(clip_count != '1);
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= MEM_IDLE;
      mem_cmd <= '0;
    end else begin
      state <= state_nxt;
      if (pop) mem_cmd <= head;
    end
  // a pop always (re)loads the port; an ack with nothing queued returns to idle
  always_comb begin
    state_nxt = state;
    if (pop) state_nxt = MEM_REQ;
    else if (bus.mem_ack) state_nxt = MEM_IDLE;
  end
endmodule

// File: tb/tb_saph_pixel_writer.sv
// tb_saph_pixel_writer: directed and randomized checks of saph_pixel_writer against an arithmetic model
module tb_saph_pixel_writer;
  import saph_pixel_writer_pkg::*;
  localparam int DEPTH = 4;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] cfg_base;
  logic [15:0] cfg_stride, cfg_width, cfg_height;
  logic [1:0]  cfg_fmt;
  logic        busy;
  logic [15:0] clip_count;
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int req_cycles = 0;
  int exp_clips = 0;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          t;
  } wr_t;
  wr_t       obs_q[$];
  mem_wr_cmd exp_q[$];
  saph_pixel_writer_if bus();
  saph_pixel_writer #(.FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cfg_base(cfg_base), .cfg_stride(cfg_stride), .cfg_width(cfg_width),
    .cfg_height(cfg_height), .cfg_fmt(cfg_fmt), .bus(bus), .busy(busy), .clip_count(clip_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rst && bus.mem_req) req_cycles++;
    if (rst && bus.mem_req && bus.mem_ack)
      obs_q.push_back(wr_t'{bus.mem_addr, bus.mem_wdata, bus.mem_wmask, cyc});
  end
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks required completion", n_checks);
    $fatal(1);
  end
  function automatic bit model(input int x, input int y, input logic [31:0] col, input logic [31:0] base,
                               input int stride, input int w, input int h, input int fmt,
                               output mem_wr_cmd c);
    int bpp, r, g, b, p, off;
    logic [31:0] ba;
    c = '0;
    if (x < 0 || y < 0 || x >= w || y >= h || fmt == 3) return 1'b1;
    bpp = fmt == 0 ? 4 : fmt == 1 ? 2 : 1;
    ba  = 32'(longint'(base) + longint'(y) * stride + longint'(x) * bpp);
    off = int'(ba % 4);
    r = int'(col[23:16]);
    g = int'(col[15:8]);
    b = int'(col[7:0]);
    c.addr = ba - 32'(off);
    if (fmt == 0) begin
      c.wdata = col;
      c.wmask = 4'b1111;
    end else if (fmt == 1) begin
      p = (r / 8) * 2048 + (g / 4) * 32 + b / 8;
      c.wdata = 32'(p * 65537);
      c.wmask = off >= 2 ? 4'b1100 : 4'b0011;
    end else begin
      p = (r / 32) * 32 + (g / 32) * 4 + b / 64;
      c.wdata = 32'(p) * 32'h01010101;
      c.wmask = 4'(1 << off);
    end
    return 1'b0;
  endfunction
  function automatic pixel_t mk_pix(input int x, input int y, input logic [31:0] col);
    pixel_t p;
    p.x = 16'(x);
    p.y = 16'(y);
    p.col = col;
    return p;
  endfunction
  task automatic model_accept(input pixel_t p);
    mem_wr_cmd c;
    if (model(int'(p.x), int'(p.y), p.col, cfg_base, int'(cfg_stride), int'(cfg_width),
              int'(cfg_height), int'(cfg_fmt), c)) exp_clips++;
    else exp_q.push_back(c);
  endtask
  task automatic set_cfg(input logic [31:0] base, input logic [15:0] stride, input logic [15:0] w,
                         input logic [15:0] h, input logic [1:0] fmt);
    cfg_base = base;
    cfg_stride = stride;
    cfg_width = w;
    cfg_height = h;
    cfg_fmt = fmt;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    bus.in_trig = 1'b0;
    bus.in_pixel = '0;
    bus.mem_ack = 1'b0;
    set_cfg(0, 16'h400, 16'd640, 16'd480, 2'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    obs_q.delete();
    exp_q.delete();
    exp_clips = 0;
    req_cycles = 0;
  endtask
  task automatic send_one(input pixel_t p, output int acc);
    bit done = 1'b0;
    bus.in_trig = 1'b1;
    bus.in_pixel = p;
    acc = -1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        model_accept(p);
        acc = cyc + 1;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_trig = 1'b0;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL send_accept: in_ready never rose within 50 cycles, required 1");
    end
  endtask
  task automatic test_reset();
    int acc;
    do_reset();
    bus.mem_ack = 1'b0;
    send_one(mk_pix(1, 1, 32'hAABBCCDD), acc);
    send_one(mk_pix(2, 1, 32'h01020304), acc);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_req: mem_req=%b required 1", bus.mem_req);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.in_ready, bus.mem_req, bus.mem_addr, bus.mem_wdata, bus.mem_wmask, busy, clip_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b req=%b addr=%h wd=%h wm=%b busy=%b clip=%0d required all 0",
               bus.in_ready, bus.mem_req, bus.mem_addr, bus.mem_wdata, bus.mem_wmask, busy, clip_count);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_ready: in_ready=%b required 0 before first clk", bus.in_ready);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || clip_count !== 16'd0 || bus.mem_req !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_clk: rdy=%b clip=%0d req=%b busy=%b required 1,0,0,0",
               bus.in_ready, clip_count, bus.mem_req, busy);
    end
  endtask
  task automatic test_format(input string name, input logic [31:0] base, input logic [15:0] stride,
                             input logic [1:0] fmt, input int x, input int y, input logic [31:0] col,
                             input logic [31:0] e_addr, input logic [31:0] e_wdata, input logic [3:0] e_wmask);
    int acc;
    do_reset();
    set_cfg(base, stride, 16'd640, 16'd480, fmt);
    bus.mem_ack = 1'b1;
    send_one(mk_pix(x, y, col), acc);
    n_checks++;
    if (bus.mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_lat0: mem_req=%b at accept edge required 0", name, bus.mem_req);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_lat1: mem_req=%b one edge after accept required 0", name, bus.mem_req);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== e_addr || bus.mem_wdata !== e_wdata || bus.mem_wmask !== e_wmask) begin
      n_fail++;
      $display("FAIL %s_write: req=%b addr=%h wdata=%h wmask=%b required 1 %h %h %b", name,
               bus.mem_req, bus.mem_addr, bus.mem_wdata, bus.mem_wmask, e_addr, e_wdata, e_wmask);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || obs_q.size() != 1) begin
      n_fail++;
      $display("FAIL %s_drain: busy=%b writes=%0d required 0 and 1", name, busy, obs_q.size());
    end
  endtask
  task automatic test_clip();
    int acc;
    do_reset();
    set_cfg(32'h0, 16'h400, 16'd320, 16'd240, 2'd0);
    bus.mem_ack = 1'b1;
    send_one(mk_pix(-1, 0, 32'h1), acc);
    send_one(mk_pix(320, 5, 32'h2), acc);
    send_one(mk_pix(0, 240, 32'h3), acc);
    cfg_fmt = 2'd3;
    send_one(mk_pix(10, 10, 32'h4), acc);
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (req_cycles != 0 || clip_count !== 16'd4 || exp_clips != 4) begin
      n_fail++;
      $display("FAIL clip_drop: req_cycles=%0d clip_count=%0d required 0 and 4", req_cycles, clip_count);
    end
    cfg_fmt = 2'd0;
    send_one(mk_pix(319, 239, 32'h55667788), acc);
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      n_fail++;
      $display("FAIL clip_corner_count: writes=%0d required 1", obs_q.size());
    end else if (obs_q[0].addr !== 32'(239 * 1024 + 319 * 4) || obs_q[0].wdata !== 32'h55667788) begin
      n_fail++;
      $display("FAIL clip_corner: addr=%h wdata=%h required %h 55667788", obs_q[0].addr, obs_q[0].wdata,
               32'(239 * 1024 + 319 * 4));
    end
    n_checks++;
    if (clip_count !== 16'd4) begin
      n_fail++;
      $display("FAIL clip_corner_cnt: clip_count=%0d required 4", clip_count);
    end
  endtask
  task automatic test_back_to_back();
    int k = 0;
    int before_drop = -1;
    pixel_t pix[10];
    do_reset();
    set_cfg(32'h2000, 16'h500, 16'd640, 16'd480, 2'($urandom_range(0, 2)));
    for (int i = 0; i < 10; i++) pix[i] = mk_pix(int'($urandom_range(0, 99)), int'($urandom_range(0, 99)), $urandom);
    bus.mem_ack = 1'b0;
    for (int c = 0; c < 200 && k < 10; c++) begin
      if (c == 20) bus.mem_ack = 1'b1;
      bus.in_trig = 1'b1;
      bus.in_pixel = pix[k];
      @(negedge clk);
      if (bus.in_ready) begin
        model_accept(pix[k]);
        k++;
      end else if (before_drop < 0) before_drop = k;
      @(posedge clk);
      #1;
    end
    bus.in_trig = 1'b0;
    bus.mem_ack = 1'b1;
    for (int c = 0; c < 100 && obs_q.size() < 10; c++) @(posedge clk);
    #1;
    n_checks++;
    if (before_drop != DEPTH + 2) begin
      n_fail++;
      $display("FAIL bp_ready_drop: accepts before in_ready fell=%0d required %0d", before_drop, DEPTH + 2);
    end
    n_checks++;
    if (obs_q.size() != 10 || exp_q.size() != 10) begin
      n_fail++;
      $display("FAIL bp_count: writes=%0d required 10", obs_q.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        n_checks++;
        if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].wdata !== exp_q[i].wdata || obs_q[i].wmask !== exp_q[i].wmask) begin
          n_fail++;
          $display("FAIL bp_write%0d: %h/%h/%b required %h/%h/%b", i, obs_q[i].addr, obs_q[i].wdata,
                   obs_q[i].wmask, exp_q[i].addr, exp_q[i].wdata, exp_q[i].wmask);
        end
      end
      n_checks++;
      if (obs_q[9].t - obs_q[0].t != 9) begin
        n_fail++;
        $display("FAIL bp_back_to_back: 10 acks spread over %0d edges required 9", obs_q[9].t - obs_q[0].t);
      end
    end
  endtask
  task automatic test_random();
    pixel_t p;
    int n;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      set_cfg($urandom, 16'($urandom_range(0, 4096)), 16'($urandom_range(0, 200)),
              16'($urandom_range(0, 200)), 2'($urandom_range(0, 3)));
      p = mk_pix(int'($urandom_range(0, 240)) - 20, int'($urandom_range(0, 240)) - 20, $urandom);
      bus.in_pixel = p;
      bus.in_trig = $urandom_range(0, 9) < 7;
      bus.mem_ack = $urandom_range(0, 1) == 1;
      @(negedge clk);
      if (bus.in_trig && bus.in_ready) model_accept(p);
      @(posedge clk);
      #1;
    end
    bus.in_trig = 1'b0;
    bus.mem_ack = 1'b1;
    for (int c = 0; c < 200 && busy; c++) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rnd_drain: busy=%b writes=%0d required 0 and %0d", busy, obs_q.size(), exp_q.size());
    end
    n = obs_q.size() < exp_q.size() ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].wdata !== exp_q[i].wdata || obs_q[i].wmask !== exp_q[i].wmask) begin
        n_fail++;
        $display("FAIL rnd_write%0d: %h/%h/%b required %h/%h/%b", i, obs_q[i].addr, obs_q[i].wdata,
                 obs_q[i].wmask, exp_q[i].addr, exp_q[i].wdata, exp_q[i].wmask);
      end
    end
    n_checks++;
    if (clip_count !== 16'(exp_clips)) begin
      n_fail++;
      $display("FAIL rnd_clip_count: clip_count=%0d required %0d", clip_count, exp_clips);
    end
  endtask
  initial begin
    test_reset();
    test_format("argb", 32'h1000, 16'h400, 2'd0, 3, 2, 32'h11223344, 32'h180C, 32'h11223344, 4'b1111);
    test_format("rgb565", 32'h0, 16'h100, 2'd1, 5, 0, 32'h00FF8040, 32'h8, 32'hFC08FC08, 4'b1100);
    test_format("rgb332", 32'h0, 16'h100, 2'd2, 6, 0, 32'h00E0E0C0, 32'h4, 32'hFFFFFFFF, 4'b0100);
    test_clip();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
